// File: rtl/mmss_tick_counter_pkg.sv
// Shared types and helpers for the MM:SS tick counter: BCD digit type,
// per-digit limits and a range check used by load validation.
package mmss_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_T_MAX = 4'd5;
  localparam bcd_t DIG_MAX   = 4'd9;

  function automatic logic bcd_valid(bcd_t d, bcd_t max);
    return (d <= max);
  endfunction

endpackage

// File: rtl/mmss_tick_counter_if.sv
// Control inputs and display/pulse outputs of the MM:SS tick counter.
// The bench drives through master; the counter sits on slave.
interface mmss_tick_counter_if;
  import mmss_pkg::*;

  logic        tick_in;
  logic        run;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  bcd_t        sec_o;
  bcd_t        sec_t;
  bcd_t        min_o;
  bcd_t        min_t;
  logic        tick_seen;
  logic        wrap;
  logic        load_err;

  modport master (
    output tick_in, run, clr, load, load_val,
    input  sec_o, sec_t, min_o, min_t, tick_seen, wrap, load_err
  );

  modport slave (
    input  tick_in, run, clr, load, load_val,
    output sec_o, sec_t, min_o, min_t, tick_seen, wrap, load_err
  );

endinterface

// File: rtl/mmss_tick_counter_bcd_digit.sv
// One mod-(max+1) BCD digit with clear > load > increment priority.
// carry_out is combinational so a whole carry chain settles in one cycle.
module bcd_digit
  import mmss_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic inc,
  input  bcd_t max,
  output bcd_t q,
  output logic carry_out
);

  bcd_t q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = ld_val;
    end else if (inc) begin
      q_d = (q_q == max) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc & (q_q == max);

endmodule

// File: rtl/mmss_tick_counter.sv
// BCD MM:SS counter advanced by rising edges of an asynchronous tick_in.
// Holds the synchroniser, edge detect, load check, priority and pulse regs.
module mmss_tick_counter
  import mmss_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN_T   = 5
)
(
  input  logic                clk,
  input  logic                rst,
  mmss_tick_counter_if.slave  bus
);

  localparam bcd_t MIN_T_MAX = bcd_t'(MAX_MIN_T);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic [SYNC_STAGES-1:0] prime_d, prime_q;
  logic hist_d, hist_q;
  logic arm_d, arm_q;
  logic tick_seen_d, tick_seen_q;
  logic wrap_d, wrap_q;
  logic load_err_d, load_err_q;

  logic sync_out;
  logic load_ok;
  logic ld_en;
  logic cnt_en;
  logic c_so, c_st, c_mo, c_mt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  assign load_ok = bcd_valid(bus.load_val[3:0],   DIG_MAX)
                 & bcd_valid(bus.load_val[7:4],   SEC_T_MAX)
                 & bcd_valid(bus.load_val[11:8],  DIG_MAX)
                 & bcd_valid(bus.load_val[15:12], MIN_T_MAX);

  assign ld_en  = ~bus.clr & bus.load & load_ok;
  assign cnt_en = ~bus.clr & ~ld_en & tick_seen_q & bus.run;

  // prime_q tracks when sync_out holds a real sample; arm_q then waits for
  // a low level so a tick_in held high through reset is not taken as an edge.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.tick_in};
    prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
    hist_d      = sync_out;
    arm_d       = arm_q | (prime_q[SYNC_STAGES-1] & ~sync_out);
    tick_seen_d = sync_out & ~hist_q & arm_q;
    wrap_d      = c_mt;
    load_err_d  = ~bus.clr & bus.load & ~load_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      prime_q     <= '0;
      hist_q      <= 1'b0;
      arm_q       <= 1'b0;
      tick_seen_q <= 1'b0;
      wrap_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prime_q     <= prime_d;
      hist_q      <= hist_d;
      arm_q       <= arm_d;
      tick_seen_q <= tick_seen_d;
      wrap_q      <= wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  bcd_digit u_sec_o (
    .clk(clk), .rst(rst), .clr(bus.clr), .ld(ld_en), .ld_val(bus.load_val[3:0]),
    .inc(cnt_en), .max(DIG_MAX), .q(bus.sec_o), .carry_out(c_so)
  );

  bcd_digit u_sec_t (
    .clk(clk), .rst(rst), .clr(bus.clr), .ld(ld_en), .ld_val(bus.load_val[7:4]),
    .inc(c_so), .max(SEC_T_MAX), .q(bus.sec_t), .carry_out(c_st)
  );

  bcd_digit u_min_o (
    .clk(clk), .rst(rst), .clr(bus.clr), .ld(ld_en), .ld_val(bus.load_val[11:8]),
    .inc(c_st), .max(DIG_MAX), .q(bus.min_o), .carry_out(c_mo)
  );

  bcd_digit u_min_t (
    .clk(clk), .rst(rst), .clr(bus.clr), .ld(ld_en), .ld_val(bus.load_val[15:12]),
    .inc(c_mo), .max(MIN_T_MAX), .q(bus.min_t), .carry_out(c_mt)
  );

  assign bus.tick_seen = tick_seen_q;
  assign bus.wrap      = wrap_q;
  assign bus.load_err  = load_err_q;

endmodule
